uart_rx: RTL and testbench

Oversampling UART receiver. It converts the asynchronous serial line into parallel bytes: 8N1 framing, LSB first. It sits on the inbound side of the room-terminal serial link, mirroring the transmit path, and hands each byte to the command parser as a one-cycle strobe. It contains its own fractional oversampling tick generator, so it has no external tick input.

---
 rtl/uart_rx_if.sv | 24 ++
 rtl/uart_rx.sv | 157 +++++++++++++++
 tb/tb_uart_rx.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Receive-side handshake bundle: parallel byte, strobes and line status.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_data_ready;
  logic       rx_framing_error;
  logic       rx_busy;
  logic       rx_idle;

  modport master (
    output rx_data,
    output rx_data_ready,
    output rx_framing_error,
    output rx_busy,
    output rx_idle
  );

  modport slave (
    input rx_data,
    input rx_data_ready,
    input rx_framing_error,
    input rx_busy,
    input rx_idle
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 oversampling UART receiver with internal fractional tick generator,
// break handling and line-idle detection.
module uart_rx #(
  parameter int unsigned CLK_FREQUENCY = 50_000_000,
  parameter int unsigned BAUD_RATE     = 115200,
  parameter int unsigned OVERSAMPLING  = 8
) (
  input  logic      FPGA_CLK1_50,
  input  logic      reset,
  input  logic      rxd,
  uart_rx_if.master rx
);

  localparam int unsigned DIV      = CLK_FREQUENCY / (BAUD_RATE * OVERSAMPLING);
  localparam int unsigned ACC_W    = $clog2(DIV + 1) + 8;
  localparam logic [63:0] NUM      = (64'(BAUD_RATE) * 64'(OVERSAMPLING)) << ACC_W;
  localparam logic [63:0] INC_FULL = (NUM * 64'd2 + 64'(CLK_FREQUENCY)) / (64'(CLK_FREQUENCY) * 64'd2);
  localparam logic [ACC_W:0] INC   = INC_FULL[ACC_W:0];

  localparam logic [3:0]  HALF     = 4'(OVERSAMPLING / 2 - 1);
  localparam logic [3:0]  LAST     = 4'(OVERSAMPLING - 1);
  localparam int unsigned IDLE_MAX = 2 * OVERSAMPLING;
  localparam int unsigned IW       = $clog2(IDLE_MAX + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t         state, state_n;
  logic [ACC_W:0] acc;
  logic           tick;
  logic [1:0]     sync;
  logic           rxs;
  logic [3:0]     cnt, cnt_n;
  logic [2:0]     idx, idx_n;
  logic [7:0]     shreg, shreg_n;
  logic [7:0]     data_q, data_n;
  logic           ready_q, ready_n;
  logic           ferr_q, ferr_n;
  logic           busy_q;
  logic [IW-1:0]  idle_cnt, idle_n;

  assign tick = acc[ACC_W];
  assign rxs  = sync[1];

  always_ff @(posedge FPGA_CLK1_50 or posedge reset) begin
    if (reset) begin
      acc  <= '0;
      sync <= '1;
    end else begin
      acc  <= {1'b0, acc[ACC_W-1:0]} + INC;
      sync <= {sync[0], rxd};
    end
  end

  always_ff @(posedge FPGA_CLK1_50 or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      shreg    <= '0;
      data_q   <= '0;
      ready_q  <= 1'b0;
      ferr_q   <= 1'b0;
      busy_q   <= 1'b0;
      idle_cnt <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      shreg    <= shreg_n;
      data_q   <= data_n;
      ready_q  <= ready_n;
      ferr_q   <= ferr_n;
      busy_q   <= (state_n != IDLE);
      idle_cnt <= idle_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    data_n  = data_q;
    ready_n = 1'b0;
    ferr_n  = 1'b0;
    if (tick) begin
      unique case (state)
        IDLE: begin
          if (!rxs) begin
            state_n = START;
            cnt_n   = '0;
          end
        end
        START: begin
          if (cnt == HALF) begin
            cnt_n = '0;
            if (!rxs) begin
              state_n = DATA;
              idx_n   = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            shreg_n = {rxs, shreg[7:1]};
            cnt_n   = '0;
            idx_n   = idx + 3'd1;
            if (idx == 3'd7) state_n = STOP;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
        STOP: begin
          if (cnt == LAST) begin
            cnt_n = '0;
            if (rxs) begin
              data_n  = shreg;
              ready_n = 1'b1;
              state_n = IDLE;
            end else begin
              ferr_n  = 1'b1;
              state_n = BREAK;
            end
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
        BREAK: begin
          // Wait for the line to recover so a held-low line is not re-read as starts.
          if (rxs) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    idle_n = idle_cnt;
    if (state != IDLE) begin
      idle_n = '0;
    end else if (tick) begin
      if (!rxs) idle_n = '0;
      else if (idle_cnt != IW'(IDLE_MAX)) idle_n = idle_cnt + IW'(1);
    end
  end

  assign rx.rx_data          = data_q;
  assign rx.rx_data_ready    = ready_q;
  assign rx.rx_framing_error = ferr_q;
  assign rx.rx_busy          = busy_q;
  assign rx.rx_idle          = (idle_cnt == IW'(IDLE_MAX));

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: drives a UART line model and checks strobes, data and status.
module tb_uart_rx;
  logic clk = 1'b0;
  logic rst;
  logic rxd;

  always #10 clk = ~clk;

  uart_rx_if rx_bus ();

  uart_rx #(
    .CLK_FREQUENCY(50_000_000),
    .BAUD_RATE    (115200),
    .OVERSAMPLING (8)
  ) dut (
    .FPGA_CLK1_50(clk),
    .reset       (rst),
    .rxd         (rxd),
    .rx          (rx_bus)
  );

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int n_ready = 0;
  int n_ferr = 0;
  int n_both = 0;
  int ready_cyc = 0;
  int fall_cyc = 0;
  int busy_cycles = 0;
  int idle_rise_cyc = 0;
  int idle_in_burst = 0;
  logic burst = 1'b0;
  logic prev_idle = 1'b0;
  logic [7:0] cap [32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int val, input int lo, input int hi);
    checks++;
    if (val < lo || val > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", tag, val, lo, hi);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rx_bus.rx_data_ready) begin
      if (n_ready < 32) cap[n_ready] = rx_bus.rx_data;
      n_ready++;
      ready_cyc = cyc;
    end
    if (rx_bus.rx_framing_error) n_ferr++;
    if (rx_bus.rx_data_ready && rx_bus.rx_framing_error) n_both++;
    if (rx_bus.rx_busy) busy_cycles++;
    if (rx_bus.rx_idle && !prev_idle) idle_rise_cyc = cyc;
    if (burst && rx_bus.rx_idle) idle_in_burst++;
    prev_idle = rx_bus.rx_idle;
  end

  task automatic send_byte(input logic [7:0] b, input int bp, input logic stop);
    logic [7:0] v;
    v = b;
    @(negedge clk);
    rxd = 1'b0;
    fall_cyc = cyc;
    repeat (bp) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = v[i];
      repeat (bp) @(negedge clk);
    end
    rxd = stop;
    repeat (bp) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},  32'(rx_bus.rx_data), 32'h00);
    check({tag, "_ready"}, 32'(rx_bus.rx_data_ready), 32'h0);
    check({tag, "_ferr"},  32'(rx_bus.rx_framing_error), 32'h0);
    check({tag, "_busy"},  32'(rx_bus.rx_busy), 32'h0);
    check({tag, "_idle"},  32'(rx_bus.rx_idle), 32'h0);
  endtask

  initial begin
    int base;
    int ferr_base;
    rst = 1'b1;
    rxd = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    repeat (1000) @(negedge clk);
    check("idle_after_rst", 32'(rx_bus.rx_idle), 32'h1);

    // Glitch: 100 clocks low must be rejected at the half-bit start check.
    base = n_ready;
    busy_cycles = 0;
    rxd = 1'b0;
    repeat (100) @(negedge clk);
    rxd = 1'b1;
    repeat (400) @(negedge clk);
    check("glitch_busy", 32'(rx_bus.rx_busy), 32'h0);
    check("glitch_strobe", 32'(n_ready - base), 32'd0);
    check("glitch_data", 32'(rx_bus.rx_data), 32'h00);
    check_range("glitch_busy_len", busy_cycles, 200, 235);

    // Single bytes
    base = n_ready;
    busy_cycles = 0;
    send_byte(8'h55, 434, 1'b1);
    repeat (50) @(negedge clk);
    check("b55_count", 32'(n_ready - base), 32'd1);
    check("b55_data", 32'(rx_bus.rx_data), 32'h55);
    check_range("b55_latency", ready_cyc - fall_cyc, 4067, 4187);
    check_range("b55_busy_len", busy_cycles, 4060, 4190);

    base = n_ready;
    send_byte(8'hA3, 434, 1'b1);
    repeat (50) @(negedge clk);
    check("bA3_count", 32'(n_ready - base), 32'd1);
    check("bA3_data", 32'(rx_bus.rx_data), 32'hA3);
    check("ferr_none", 32'(n_ferr), 32'd0);

    // Framing error followed by a held-low line
    base = n_ready;
    send_byte(8'h3C, 434, 1'b0);
    repeat (20 * 434) @(negedge clk);
    check("fe_pulses", 32'(n_ferr), 32'd1);
    check("fe_no_strobe", 32'(n_ready - base), 32'd0);
    check("fe_data_kept", 32'(rx_bus.rx_data), 32'hA3);
    check("fe_break_busy", 32'(rx_bus.rx_busy), 32'h1);
    rxd = 1'b1;
    repeat (868) @(negedge clk);
    check("fe_break_exit", 32'(rx_bus.rx_busy), 32'h0);
    send_byte(8'h81, 434, 1'b1);
    repeat (50) @(negedge clk);
    check("b81_count", 32'(n_ready - base), 32'd1);
    check("b81_data", 32'(rx_bus.rx_data), 32'h81);

    repeat (1000) @(negedge clk);
    check("idle_pre_burst", 32'(rx_bus.rx_idle), 32'h1);

    // Back-to-back burst then idle
    base = n_ready;
    fork
      begin
        send_byte(8'h00, 434, 1'b1);
        send_byte(8'hFF, 434, 1'b1);
        send_byte(8'h7E, 434, 1'b1);
      end
      begin
        repeat (120) @(negedge clk);
        burst = 1'b1;
      end
    join
    burst = 1'b0;
    check("burst_count", 32'(n_ready - base), 32'd3);
    check("burst_d0", 32'(cap[base]), 32'h00);
    check("burst_d1", 32'(cap[base + 1]), 32'hFF);
    check("burst_d2", 32'(cap[base + 2]), 32'h7E);
    check("burst_idle_low", 32'(idle_in_burst), 32'd0);
    repeat (1200) @(negedge clk);
    check_range("idle_rise", idle_rise_cyc - ready_cyc, 808, 928);

    // Baud tolerance +3% / -3%
    ferr_base = n_ferr;
    base = n_ready;
    send_byte(8'hC3, 421, 1'b1);
    repeat (500) @(negedge clk);
    check("fast_data", 32'(rx_bus.rx_data), 32'hC3);
    check("fast_count", 32'(n_ready - base), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    base = n_ready;
    send_byte(8'hC3, 447, 1'b1);
    repeat (500) @(negedge clk);
    check("slow_data", 32'(rx_bus.rx_data), 32'hC3);
    check("slow_count", 32'(n_ready - base), 32'd1);
    check("tol_ferr", 32'(n_ferr - ferr_base), 32'd0);

    // Reset during data bit 4 of 0x96; held until the frame has passed
    base = n_ready;
    fork
      send_byte(8'h96, 434, 1'b1);
      begin
        repeat (5 * 434 + 200) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
      end
    join
    rst = 1'b0;
    repeat (500) @(negedge clk);
    check("midrst_no_strobe", 32'(n_ready - base), 32'd0);
    send_byte(8'h5A, 434, 1'b1);
    repeat (50) @(negedge clk);
    check("b5A_count", 32'(n_ready - base), 32'd1);
    check("b5A_data", 32'(rx_bus.rx_data), 32'h5A);

    check("never_both", 32'(n_both), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
